// File: rtl/svc_sim_run_mon_pkg.sv
// Shared types for the simulation run monitor.
// State encoding and the state-to-status decode live here.
package svc_sim_run_mon_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RUN     = 3'd1,
    ST_DONE    = 3'd2,
    ST_TIMEOUT = 3'd3,
    ST_STALL   = 3'd4,
    ST_FAULT   = 3'd5
  } state_e;

  // Status bundle order: {busy, done, pass, timeout, stall, fault}
  function automatic logic [5:0] status_of(input state_e s);
    logic [5:0] f;
    f = 6'b000000;
    unique case (s)
      ST_RUN:     f = 6'b100000;
      ST_DONE:    f = 6'b011000;
      ST_TIMEOUT: f = 6'b010100;
      ST_STALL:   f = 6'b010010;
      ST_FAULT:   f = 6'b010001;
      default:    f = 6'b000000;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/svc_sim_run_mon_hart.sv
// Per-hart bookkeeping: sticky halt flag, retire counter, idle counter.
// Idle counting is present only with SVC_SIM_RUN_MON_STALL_EN defined.
module svc_sim_run_mon_hart
  import svc_sim_run_mon_pkg::*;
#(
  parameter int CNT_W        = 32,
  parameter int STALL_CYCLES = 4096
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             run,
  input  logic             retire,
  input  logic             halt,
  output logic             halted_next,
  output logic             stall_hit,
  output logic [CNT_W-1:0] instret
);

  logic             halted_q, halted_d;
  logic [CNT_W-1:0] instret_q, instret_d;
  logic             active;

  // A hart only reacts while running and not yet halted
  assign active      = run && !halted_q;
  assign halted_next = halted_q || (active && halt);
  assign instret     = instret_q;

`ifdef SVC_SIM_RUN_MON_STALL_EN
  logic [CNT_W-1:0] idle_q, idle_d;

  // Stall when this cycle's idle increment reaches the limit
  always_comb begin
    stall_hit = 1'b0;
    if (active && !halt && !retire &&
        (64'(idle_q) + 64'd1 == 64'(STALL_CYCLES)))
      stall_hit = 1'b1;
  end

  // Idle counter: cleared by retire, saturating otherwise
  always_comb begin
    idle_d = idle_q;
    if (clear)
      idle_d = '0;
    else if (active) begin
      if (retire)
        idle_d = '0;
      else if (idle_q != '1)
        idle_d = idle_q + 1'b1;
    end
  end

  // Idle counter register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) idle_q <= '0;
    else     idle_q <= idle_d;
  end
`else
  logic unused_stall_cfg;
  assign unused_stall_cfg = (STALL_CYCLES == 0);
  assign stall_hit        = 1'b0;
`endif

  // Halt flag and saturating retire count
  always_comb begin
    halted_d  = halted_q;
    instret_d = instret_q;
    if (clear) begin
      halted_d  = 1'b0;
      instret_d = '0;
    end else if (active) begin
      if (halt)
        halted_d = 1'b1;
      if (retire && instret_q != '1)
        instret_d = instret_q + 1'b1;
    end
  end

  // Per-hart state registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      halted_q  <= 1'b0;
      instret_q <= '0;
    end else begin
      halted_q  <= halted_d;
      instret_q <= instret_d;
    end
  end

endmodule

// File: rtl/svc_sim_run_mon.sv
// Simulation run monitor: watchdog, completion, trap and stall detection.
// Optional stall detection is enabled with SVC_SIM_RUN_MON_STALL_EN.
module svc_sim_run_mon
  import svc_sim_run_mon_pkg::*;
#(
  parameter int NUM_HARTS       = 1,
  parameter int WATCHDOG_CYCLES = 500_000,
  parameter int STALL_CYCLES    = 4096,
  parameter int CNT_W           = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [NUM_HARTS-1:0]       hart_retire,
  input  logic [NUM_HARTS-1:0]       hart_halt,
  input  logic [NUM_HARTS-1:0]       hart_trap,
  output logic [2:0]                 state,
  output logic                       busy,
  output logic                       done,
  output logic                       pass,
  output logic                       timeout,
  output logic                       stall,
  output logic                       fault,
  output logic [CNT_W-1:0]           cycles,
  output logic [NUM_HARTS*CNT_W-1:0] instret,
  output logic [((NUM_HARTS > 1) ? $clog2(NUM_HARTS) : 1)-1:0] fault_hart
);

  localparam int FH_W = (NUM_HARTS > 1) ? $clog2(NUM_HARTS) : 1;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cycles_q, cycles_d;
  logic [FH_W-1:0]  fh_q, fh_d;
  logic [5:0]       status_q, status_d;

  logic                 run;
  logic                 clear;
  logic [NUM_HARTS-1:0] halted_next;
  logic [NUM_HARTS-1:0] stall_hit;

  assign run   = (state_q == ST_RUN);
  assign clear = start && !run;

  function automatic logic [FH_W-1:0] lowest(
    input logic [NUM_HARTS-1:0] v
  );
    logic [FH_W-1:0] r;
    r = '0;
    for (int i = NUM_HARTS - 1; i >= 0; i--)
      if (v[i]) r = FH_W'(i);
    return r;
  endfunction

  for (genvar g = 0; g < NUM_HARTS; g++) begin : g_hart
    svc_sim_run_mon_hart #(
      .CNT_W        (CNT_W),
      .STALL_CYCLES (STALL_CYCLES)
    ) u_hart (
      .clk         (clk),
      .rst         (rst),
      .clear       (clear),
      .run         (run),
      .retire      (hart_retire[g]),
      .halt        (hart_halt[g]),
      .halted_next (halted_next[g]),
      .stall_hit   (stall_hit[g]),
      .instret     (instret[g*CNT_W +: CNT_W])
    );
  end

  // Next state, run cycle count and culprit hart selection
  always_comb begin
    state_d  = state_q;
    cycles_d = cycles_q;
    fh_d     = fh_q;
    if (clear) begin
      state_d  = ST_RUN;
      cycles_d = '0;
      fh_d     = '0;
    end else if (run) begin
      if (cycles_q != '1)
        cycles_d = cycles_q + 1'b1;
      if (|hart_trap) begin
        state_d = ST_FAULT;
        fh_d    = lowest(hart_trap);
      end else if (&halted_next) begin
        state_d = ST_DONE;
      end else if (|stall_hit) begin
        state_d = ST_STALL;
        fh_d    = lowest(stall_hit);
      end else if (64'(cycles_q) == 64'(WATCHDOG_CYCLES - 1)) begin
        state_d = ST_TIMEOUT;
      end
    end
    status_d = status_of(state_d);
  end

  // Monitor registers; status flags are registered copies of the decode
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cycles_q <= '0;
      fh_q     <= '0;
      status_q <= '0;
    end else begin
      state_q  <= state_d;
      cycles_q <= cycles_d;
      fh_q     <= fh_d;
      status_q <= status_d;
    end
  end

  assign state      = state_q;
  assign cycles     = cycles_q;
  assign fault_hart = fh_q;
  assign busy       = status_q[5];
  assign done       = status_q[4];
  assign pass       = status_q[3];
  assign timeout    = status_q[2];
  assign fault      = status_q[0];

`ifdef SVC_SIM_RUN_MON_STALL_EN
  assign stall = status_q[1];
`else
  logic unused_stall_q;
  assign unused_stall_q = status_q[1];
  assign stall          = 1'b0;
`endif

endmodule

// File: tb/tb_svc_sim_run_mon.sv
// Directed bench for svc_sim_run_mon: vector table plus run sequences.
// Follows SVC_SIM_RUN_MON_STALL_EN for the stall scenario expectations.
module tb_svc_sim_run_mon;
  import svc_sim_run_mon_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic        start_a;
  logic [1:0]  ret_a, hlt_a, trp_a;
  logic [2:0]  st_a;
  logic        busy_a, done_a, pass_a, tmo_a, stl_a, flt_a;
  logic [31:0] cyc_a;
  logic [63:0] ins_a;
  logic [0:0]  fh_a;

  logic        start_b, ret_b, hlt_b, trp_b;
  logic [2:0]  st_b;
  logic        busy_b, done_b, pass_b, tmo_b, stl_b, flt_b;
  logic [3:0]  cyc_b;
  logic [3:0]  ins_b;
  logic [0:0]  fh_b;

  svc_sim_run_mon #(
    .NUM_HARTS(2), .WATCHDOG_CYCLES(100),
    .STALL_CYCLES(16), .CNT_W(32)
  ) u_a (
    .clk(clk), .rst(rst), .start(start_a),
    .hart_retire(ret_a), .hart_halt(hlt_a), .hart_trap(trp_a),
    .state(st_a), .busy(busy_a), .done(done_a), .pass(pass_a),
    .timeout(tmo_a), .stall(stl_a), .fault(flt_a),
    .cycles(cyc_a), .instret(ins_a), .fault_hart(fh_a)
  );

  svc_sim_run_mon #(
    .NUM_HARTS(1), .CNT_W(4)
  ) u_b (
    .clk(clk), .rst(rst), .start(start_b),
    .hart_retire(ret_b), .hart_halt(hlt_b), .hart_trap(trp_b),
    .state(st_b), .busy(busy_b), .done(done_b), .pass(pass_b),
    .timeout(tmo_b), .stall(stl_b), .fault(flt_b),
    .cycles(cyc_b), .instret(ins_b), .fault_hart(fh_b)
  );

  typedef struct {
    logic        start;
    logic [1:0]  ret, hlt, trp;
    logic [2:0]  st;
    logic [5:0]  fl;
    logic        fh;
    logic [31:0] cyc, i0, i1;
  } vec_t;

  vec_t tbl[13];
  int n_tests = 0;
  int n_fail  = 0;

  function automatic vec_t mk(
    logic s, logic [1:0] r, logic [1:0] h, logic [1:0] t,
    logic [2:0] st, logic [5:0] fl, logic fh,
    logic [31:0] cyc, logic [31:0] i0, logic [31:0] i1
  );
    vec_t v;
    v.start = s; v.ret = r; v.hlt = h; v.trp = t;
    v.st = st; v.fl = fl; v.fh = fh;
    v.cyc = cyc; v.i0 = i0; v.i1 = i1;
    return v;
  endfunction

  function automatic logic [5:0] flags_a();
    return {busy_a, done_a, pass_a, tmo_a, stl_a, flt_a};
  endfunction

  function automatic logic [5:0] flags_b();
    return {busy_b, done_b, pass_b, tmo_b, stl_b, flt_b};
  endfunction

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    start_a = 0; ret_a = 0; hlt_a = 0; trp_a = 0;
    start_b = 0; ret_b = 0; hlt_b = 0; trp_b = 0;
  endtask

  task automatic reset_all();
    idle_inputs();
    rst = 1;
    tick();
    rst = 0;
    tick();
  endtask

  task automatic start_a_run();
    start_a = 1;
    tick();
    start_a = 0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "bench time limit");
  end

  initial begin
    int n;

    tbl[0]  = mk(1, 2'b00, 2'b00, 2'b00, ST_RUN,   6'b100000, 0, 0, 0, 0);
    tbl[1]  = mk(0, 2'b11, 2'b00, 2'b00, ST_RUN,   6'b100000, 0, 1, 1, 1);
    tbl[2]  = mk(0, 2'b01, 2'b00, 2'b00, ST_RUN,   6'b100000, 0, 2, 2, 1);
    tbl[3]  = mk(0, 2'b00, 2'b11, 2'b10, ST_FAULT, 6'b010001, 1, 3, 2, 1);
    tbl[4]  = mk(0, 2'b11, 2'b11, 2'b00, ST_FAULT, 6'b010001, 1, 3, 2, 1);
    tbl[5]  = mk(1, 2'b00, 2'b00, 2'b00, ST_RUN,   6'b100000, 0, 0, 0, 0);
    tbl[6]  = mk(0, 2'b00, 2'b00, 2'b11, ST_FAULT, 6'b010001, 0, 1, 0, 0);
    tbl[7]  = mk(1, 2'b00, 2'b00, 2'b00, ST_RUN,   6'b100000, 0, 0, 0, 0);
    tbl[8]  = mk(0, 2'b00, 2'b01, 2'b00, ST_RUN,   6'b100000, 0, 1, 0, 0);
    tbl[9]  = mk(0, 2'b11, 2'b00, 2'b00, ST_RUN,   6'b100000, 0, 2, 0, 1);
    tbl[10] = mk(0, 2'b00, 2'b10, 2'b00, ST_DONE,  6'b011000, 0, 3, 0, 1);
    tbl[11] = mk(1, 2'b00, 2'b11, 2'b11, ST_RUN,   6'b100000, 0, 0, 0, 0);
    tbl[12] = mk(0, 2'b00, 2'b00, 2'b00, ST_RUN,   6'b100000, 0, 1, 0, 0);

    reset_all();
    chk("rst_state_a", st_a, ST_IDLE);
    chk("rst_flags_a", flags_a(), 0);
    chk("rst_cycles_a", cyc_a, 0);
    chk("rst_instret_a", ins_a, 0);
    chk("rst_fh_a", fh_a, 0);
    chk("rst_state_b", st_b, ST_IDLE);
    chk("rst_flags_b", flags_b(), 0);
    chk("rst_fh_b", fh_b, 0);

    for (int i = 0; i < 13; i++) begin
      start_a = tbl[i].start;
      ret_a   = tbl[i].ret;
      hlt_a   = tbl[i].hlt;
      trp_a   = tbl[i].trp;
      tick();
      chk($sformatf("v%0d_state", i), st_a, tbl[i].st);
      chk($sformatf("v%0d_flags", i), flags_a(), tbl[i].fl);
      chk($sformatf("v%0d_fh", i), fh_a, tbl[i].fh);
      chk($sformatf("v%0d_cycles", i), cyc_a, tbl[i].cyc);
      chk($sformatf("v%0d_i0", i), ins_a[31:0], tbl[i].i0);
      chk($sformatf("v%0d_i1", i), ins_a[63:32], tbl[i].i1);
    end
    idle_inputs();

    // Normal completion: 10 retires each, both halt at cycle 20
    reset_all();
    start_a_run();
    for (int k = 0; k < 20; k++) begin
      ret_a = (k % 2 == 0) ? 2'b11 : 2'b00;
      tick();
    end
    ret_a = 0;
    chk("done_pre_state", st_a, ST_RUN);
    chk("done_pre_cycles", cyc_a, 20);
    hlt_a = 2'b11;
    tick();
    hlt_a = 0;
    chk("done_state", st_a, ST_DONE);
    chk("done_flags", flags_a(), 6'b011000);
    chk("done_cycles", cyc_a, 21);
    chk("done_i0", ins_a[31:0], 10);
    chk("done_i1", ins_a[63:32], 10);

    // Watchdog: retire every cycle, never halt
    reset_all();
    start_a_run();
    ret_a = 2'b11;
    n = 0;
    while (st_a == ST_RUN && n < 200) begin
      tick();
      n++;
    end
    ret_a = 0;
    chk("tmo_run_len", n, 100);
    chk("tmo_state", st_a, ST_TIMEOUT);
    chk("tmo_flags", flags_a(), 6'b010100);
    chk("tmo_cycles", cyc_a, 100);
    chk("tmo_i0", ins_a[31:0], 100);
    hlt_a = 2'b11;
    ret_a = 2'b11;
    repeat (3) tick();
    idle_inputs();
    chk("tmo_hold_state", st_a, ST_TIMEOUT);
    chk("tmo_hold_cycles", cyc_a, 100);
    chk("tmo_hold_i1", ins_a[63:32], 100);

    // Hart 1 silent while hart 0 retires
    reset_all();
    start_a_run();
    ret_a = 2'b01;
    n = 0;
    while (st_a == ST_RUN && n < 200) begin
      tick();
      n++;
    end
    ret_a = 0;
`ifdef SVC_SIM_RUN_MON_STALL_EN
    chk("stl_run_len", n, 16);
    chk("stl_state", st_a, ST_STALL);
    chk("stl_flags", flags_a(), 6'b010010);
    chk("stl_fh", fh_a, 1);
    chk("stl_cycles", cyc_a, 16);
    chk("stl_i0", ins_a[31:0], 16);
`else
    chk("stl_run_len", n, 100);
    chk("stl_state", st_a, ST_TIMEOUT);
    chk("stl_flags", flags_a(), 6'b010100);
    chk("stl_fh", fh_a, 0);
    chk("stl_cycles", cyc_a, 100);
    chk("stl_i0", ins_a[31:0], 100);
`endif
    chk("stl_i1", ins_a[63:32], 0);

    // Asynchronous reset in the middle of a run
    reset_all();
    start_a_run();
    ret_a = 2'b11;
    repeat (50) tick();
    chk("rstmid_pre_cycles", cyc_a, 50);
    #2;
    rst = 1;
    #1;
    chk("rstmid_state", st_a, ST_IDLE);
    chk("rstmid_flags", flags_a(), 0);
    chk("rstmid_cycles", cyc_a, 0);
    chk("rstmid_instret", ins_a, 0);
    chk("rstmid_fh", fh_a, 0);
    ret_a = 0;
    tick();
    rst = 0;
    tick();
    chk("rstmid_post_state", st_a, ST_IDLE);
    chk("rstmid_post_flags", flags_a(), 0);

    // Narrow counters saturate
    start_b = 1;
    tick();
    start_b = 0;
    ret_b = 1;
    repeat (20) tick();
    chk("sat_run_cycles", cyc_b, 15);
    chk("sat_run_instret", ins_b, 15);
    ret_b = 0;
    hlt_b = 1;
    tick();
    hlt_b = 0;
    chk("sat_state", st_b, ST_DONE);
    chk("sat_flags", flags_b(), 6'b011000);
    chk("sat_cycles", cyc_b, 15);
    chk("sat_instret", ins_b, 15);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
